// File: rtl/arb_pkg.sv
// Shared types and defaults for mem_arbiter: FSM state encoding, grant-select
// enum and the default starvation/timeout limits.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_F    = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;

endpackage

// File: rtl/arb_prio.sv
// Combinational grant decision: data first, unless fetch has been passed over
// STARVE_MAX times in a row.
module arb_prio
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic       if_req,
    input  logic       dm_req,
    input  logic [3:0] starve_cnt,
    output gnt_t       gnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // NOTE: assign every always_comb output a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = GNT_NONE;
        if (dm_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
            gnt = GNT_D;
        end else if (if_req) begin
            gnt = GNT_F;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single-port memory with ack handshake.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err
);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 15) || (TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_param_range
        $error("mem_arbiter: STARVE_MAX or TIMEOUT out of range");
    end

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    gnt_t       gnt;
    logic [3:0] starve_cnt;
    logic       served_d;
    logic       in_busy;
    logic       finish;
    logic       abort;
    logic       grant;

    arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .if_req     (if_req),
        .dm_req     (dm_req),
        .starve_cnt (starve_cnt),
        .gnt        (gnt)
    );

    assign in_busy = (state == BUSY_F) || (state == BUSY_D);
    assign grant   = (state == IDLE) && (gnt != GNT_NONE);
    assign finish  = in_busy && (mem_ack || abort);

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wdog;
    logic       err_q;

    // Watchdog sits at zero outside BUSY, so it is already clear on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog  <= '0;
            err_q <= 1'b0;
        end else begin
            wdog <= in_busy ? wdog + 8'd1 : 8'd0;
            if (finish) begin
                err_q <= abort;
            end
        end
    end

    assign abort = in_busy && !mem_ack && (wdog == 8'(TIMEOUT - 1));
    assign err   = (state == DONE) && err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt == GNT_D) begin
                    state_nxt = BUSY_D;
                end else if (gnt == GNT_F) begin
                    state_nxt = BUSY_F;
                end
            end
            BUSY_F, BUSY_D: begin
                if (mem_ack || abort) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            served_d   <= 1'b0;
            starve_cnt <= '0;
        end else if (grant) begin
            served_d  <= (gnt == GNT_D);
            mem_we    <= (gnt == GNT_D) && dm_we;
            mem_addr  <= (gnt == GNT_D) ? dm_addr : if_addr;
            mem_wdata <= (gnt == GNT_D) ? dm_wdata : 32'h0;
            if ((gnt == GNT_D) && if_req) begin
                starve_cnt <= (starve_cnt < STARVE_LIM) ? starve_cnt + 4'd1 : STARVE_LIM;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Writes and aborted transactions return zero to the served port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (finish) begin
            if (served_d) begin
                dm_rdata <= (mem_ack && !mem_we) ? mem_rdata : 32'h0;
            end else begin
                if_rdata <= mem_ack ? mem_rdata : 32'h0;
            end
        end
    end

    assign mem_req  = in_busy;
    assign busy     = (state != IDLE);
    assign if_ready = (state == DONE) && !served_d;
    assign dm_ready = (state == DONE) && served_d;

endmodule
